// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_sequencer_if : harness/decoder <-> fetch sequencer signal bundle      |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
interface fetch_sequencer_if #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
);
    logic             Start;
    logic [PC_W-1:0]  StartAddr;
    logic             Stall;
    logic             HaltInstr;
    logic             BranchAbs;
    logic [PC_W-1:0]  Target;
    logic             BranchRel;
    logic [7:0]       Offset;
    logic [PC_W-1:0]  ProgCtr;
    logic             Busy;
    logic             Done;
    logic [CNT_W-1:0] CycleCount;

    modport master (
        output Start, StartAddr, Stall, HaltInstr, BranchAbs, Target,
               BranchRel, Offset,
        input  ProgCtr, Busy, Done, CycleCount
    );

    modport slave (
        input  Start, StartAddr, Stall, HaltInstr, BranchAbs, Target,
               BranchRel, Offset,
        output ProgCtr, Busy, Done, CycleCount
    );
endinterface
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_sequencer : program counter, run control and run-cycle counter        |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
module fetch_sequencer #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
) (
    input  wire logic         Clk,
    input  wire logic         Reset,
    fetch_sequencer_if.slave  bus
);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_ARMED = 2'd1;
    localparam logic [1:0] c_S_RUN   = 2'd2;
    localparam logic [1:0] c_S_DONE  = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  w_pc_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [PC_W-1:0]  w_offset_ext;
    logic             w_busy;
    logic             w_done;

    assign w_offset_ext = PC_W'($signed(bus.Offset));

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:  if (bus.Start)     w_state_nxt = c_S_ARMED;
            c_S_ARMED: if (!bus.Start)    w_state_nxt = c_S_RUN;
            c_S_RUN:   if (bus.HaltInstr) w_state_nxt = c_S_DONE;
            c_S_DONE:                     w_state_nxt = c_S_IDLE;
            default:                      w_state_nxt = c_S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state == c_S_RUN);
        w_done = (r_state == c_S_DONE);
    end

    // Next-PC priority in RUN: halt > stall > absolute > relative > increment.
    always_comb begin
        w_pc_nxt  = r_pc;
        w_cnt_nxt = r_cnt;
        case (r_state)
            c_S_IDLE, c_S_ARMED: begin
                if (bus.Start) begin
                    w_pc_nxt  = bus.StartAddr;
                    w_cnt_nxt = '0;
                end
            end
            c_S_RUN: begin
                if (r_cnt != {CNT_W{1'b1}}) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
                if (bus.HaltInstr || bus.Stall) begin
                    w_pc_nxt = r_pc;
                end else if (bus.BranchAbs) begin
                    w_pc_nxt = bus.Target;
                end else if (bus.BranchRel) begin
                    w_pc_nxt = r_pc + w_offset_ext;
                end else begin
                    w_pc_nxt = r_pc + PC_W'(1);
                end
            end
            default: begin
                w_pc_nxt  = r_pc;
                w_cnt_nxt = r_cnt;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_pc  <= '0;
            r_cnt <= '0;
        end else begin
            r_pc  <= w_pc_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

    assign bus.ProgCtr    = r_pc;
    assign bus.CycleCount = r_cnt;
    assign bus.Busy       = w_busy;
    assign bus.Done       = w_done;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_sequencer : directed self-checking bench for fetch_sequencer       |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
module tb_fetch_sequencer;

    logic Clk;
    logic Reset;
    int   n_vec;
    int   n_err;

    fetch_sequencer_if #(.PC_W(10), .CNT_W(16)) m_if ();
    fetch_sequencer_if #(.PC_W(10), .CNT_W(4))  s_if ();

    fetch_sequencer #(.PC_W(10), .CNT_W(16)) u_dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (m_if.slave)
    );

    fetch_sequencer #(.PC_W(10), .CNT_W(4)) u_dut_small (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (s_if.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic launch_m(input logic [9:0] addr);
        m_if.StartAddr = addr;
        m_if.Start     = 1'b1;
        tick();
        m_if.Start     = 1'b0;
        tick();
    endtask

    task automatic halt_m();
        m_if.HaltInstr = 1'b1;
        tick();
        chk("halt_done", m_if.Done, 1);
        chk("halt_busy", m_if.Busy, 0);
        m_if.HaltInstr = 1'b0;
        tick();
        chk("halt_done_drop", m_if.Done, 0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        Reset = 1'b0;
        m_if.Start = 0; m_if.StartAddr = '0; m_if.Stall = 0; m_if.HaltInstr = 0;
        m_if.BranchAbs = 0; m_if.Target = '0; m_if.BranchRel = 0; m_if.Offset = '0;
        s_if.Start = 0; s_if.StartAddr = '0; s_if.Stall = 0; s_if.HaltInstr = 0;
        s_if.BranchAbs = 0; s_if.Target = '0; s_if.BranchRel = 0; s_if.Offset = '0;
        tick();
        tick();
        chk("rst_pc",   m_if.ProgCtr, 0);
        chk("rst_busy", m_if.Busy, 0);
        chk("rst_done", m_if.Done, 0);
        chk("rst_cnt",  m_if.CycleCount, 0);
        Reset = 1'b1;

        // Launch at 0x010 with Start held three cycles, halt on the fourth RUN cycle.
        m_if.StartAddr = 10'h010;
        m_if.Start     = 1'b1;
        tick();
        chk("armed_pc", m_if.ProgCtr, 10'h010);
        chk("armed_busy", m_if.Busy, 0);
        m_if.StartAddr = 10'h011;
        tick();
        chk("armed_track", m_if.ProgCtr, 10'h011);
        m_if.StartAddr = 10'h010;
        tick();
        m_if.Start = 1'b0;
        tick();
        chk("run1_pc",   m_if.ProgCtr, 10'h010);
        chk("run1_busy", m_if.Busy, 1);
        chk("run1_cnt",  m_if.CycleCount, 0);
        tick();
        chk("run2_pc", m_if.ProgCtr, 10'h011);
        tick();
        chk("run3_pc", m_if.ProgCtr, 10'h012);
        tick();
        chk("run4_pc", m_if.ProgCtr, 10'h013);
        m_if.HaltInstr = 1'b1;
        tick();
        chk("done_pc",   m_if.ProgCtr, 10'h013);
        chk("done_pulse", m_if.Done, 1);
        chk("done_busy", m_if.Busy, 0);
        chk("done_cnt",  m_if.CycleCount, 4);
        m_if.HaltInstr = 1'b0;
        tick();
        chk("idle_done", m_if.Done, 0);
        chk("idle_pc",   m_if.ProgCtr, 10'h013);
        chk("idle_cnt",  m_if.CycleCount, 4);

        // Relative branches and wrap.
        launch_m(10'h020);
        m_if.BranchRel = 1'b1; m_if.Offset = 8'hFB;
        tick();
        chk("rel_neg", m_if.ProgCtr, 10'h01B);
        m_if.Offset = 8'h7F;
        tick();
        chk("rel_pos", m_if.ProgCtr, 10'h09A);
        m_if.BranchRel = 1'b0;
        m_if.BranchAbs = 1'b1; m_if.Target = 10'h3FE;
        tick();
        chk("abs_3fe", m_if.ProgCtr, 10'h3FE);
        m_if.BranchAbs = 1'b0;
        tick();
        chk("inc_3ff", m_if.ProgCtr, 10'h3FF);
        tick();
        chk("inc_wrap", m_if.ProgCtr, 10'h000);
        m_if.BranchRel = 1'b1; m_if.Offset = 8'hFF;
        tick();
        chk("rel_wrap", m_if.ProgCtr, 10'h3FF);
        m_if.BranchRel = 1'b0;

        // Absolute beats relative; stall beats both.
        m_if.BranchAbs = 1'b1; m_if.Target = 10'h040;
        tick();
        chk("abs_040", m_if.ProgCtr, 10'h040);
        m_if.Target = 10'h155; m_if.BranchRel = 1'b1; m_if.Offset = 8'h02;
        tick();
        chk("abs_over_rel", m_if.ProgCtr, 10'h155);
        m_if.BranchRel = 1'b0; m_if.Target = 10'h040;
        tick();
        m_if.Target = 10'h155; m_if.BranchRel = 1'b1; m_if.Stall = 1'b1;
        tick();
        chk("stall_over_br", m_if.ProgCtr, 10'h040);
        m_if.Stall = 1'b0; m_if.BranchRel = 1'b0;

        // Three-cycle stall.
        m_if.Target = 10'h030;
        tick();
        m_if.BranchAbs = 1'b0;
        begin
            logic [15:0] c0;
            c0 = m_if.CycleCount;
            m_if.Stall = 1'b1;
            for (int i = 0; i < 3; i++) begin
                tick();
                chk("stall_hold", m_if.ProgCtr, 10'h030);
            end
            m_if.Stall = 1'b0;
            tick();
            chk("stall_release", m_if.ProgCtr, 10'h031);
            chk("stall_cnt", m_if.CycleCount, 32'(c0) + 4);
        end
        halt_m();

        // Reset mid-RUN at PC=0x05A, CycleCount=37.
        launch_m(10'h05A);
        m_if.Stall = 1'b1;
        repeat (37) tick();
        chk("pre_rst_pc",  m_if.ProgCtr, 10'h05A);
        chk("pre_rst_cnt", m_if.CycleCount, 37);
        Reset = 1'b0;
        tick();
        chk("mrst_pc",   m_if.ProgCtr, 0);
        chk("mrst_cnt",  m_if.CycleCount, 0);
        chk("mrst_busy", m_if.Busy, 0);
        chk("mrst_done", m_if.Done, 0);
        Reset = 1'b1;
        m_if.Stall = 1'b0;
        tick();
        chk("mrst_idle_busy", m_if.Busy, 0);
        chk("mrst_idle_pc",   m_if.ProgCtr, 0);

        // Saturating 4-bit counter over a 20-cycle run with Start toggling.
        s_if.StartAddr = 10'h100;
        s_if.Start     = 1'b1;
        tick();
        s_if.Start     = 1'b0;
        tick();
        chk("sat_run_busy", s_if.Busy, 1);
        for (int i = 0; i < 20; i++) begin
            s_if.Start = i[0];
            tick();
            if (i == 13) chk("sat_cnt14", s_if.CycleCount, 14);
        end
        s_if.Start = 1'b0;
        chk("sat_cnt",  s_if.CycleCount, 15);
        chk("sat_busy", s_if.Busy, 1);
        chk("sat_pc",   s_if.ProgCtr, 10'h114);
        s_if.HaltInstr = 1'b1;
        tick();
        chk("sat_done", s_if.Done, 1);
        chk("sat_done_cnt", s_if.CycleCount, 15);
        s_if.HaltInstr = 1'b0;
        tick();
        chk("sat_idle_cnt", s_if.CycleCount, 15);
        s_if.StartAddr = 10'h200;
        s_if.Start     = 1'b1;
        tick();
        chk("rearm_cnt", s_if.CycleCount, 0);
        chk("rearm_pc",  s_if.ProgCtr, 10'h200);
        s_if.Start = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
